// File: rtl/free_list_bank.sv
// One bank of the physical-register free list: a circular FIFO of bank-local
// PR indices feeding rename, with occupancy count, threshold flags and sticky errors.
`timescale 1ns/1ps
module free_list_bank #(
  parameter  int unsigned PR_COUNT        = 128,
  parameter  int unsigned BANK_COUNT      = 4,
  parameter  int unsigned BANK_ID         = 0,
  parameter  int unsigned AR_COUNT        = 32,
  parameter  int unsigned LOWER_THRESHOLD = 8,
  parameter  int unsigned UPPER_THRESHOLD = 24,
  localparam int unsigned DEPTH           = PR_COUNT / BANK_COUNT,
  localparam int unsigned IDX_W           = $clog2(DEPTH),
  localparam int unsigned TAG_W           = $clog2(PR_COUNT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq_valid,
  input  logic [TAG_W-1:0] enq_PR_tag,
  output logic             deq_valid,
  output logic [TAG_W-1:0] deq_PR_tag,
  input  logic             deq_ready,
  output logic [IDX_W:0]   count,
  output logic             low_flag,
  output logic             high_flag,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             bank_err
);

  localparam int unsigned      BNK_W       = $clog2(BANK_COUNT);
  localparam int unsigned      AR_PER_BANK = AR_COUNT / BANK_COUNT;
  localparam int unsigned      FREE_AT_RST = DEPTH - AR_PER_BANK;
  localparam logic [BNK_W-1:0] BANK_BITS   = BNK_W'(BANK_ID);
  localparam logic [IDX_W:0]   DEPTH_C     = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   LOW_C       = (IDX_W+1)'(LOWER_THRESHOLD);
  localparam logic [IDX_W:0]   HIGH_C      = (IDX_W+1)'(UPPER_THRESHOLD);
  localparam logic [IDX_W:0]   RST_CNT_C   = (IDX_W+1)'(FREE_AT_RST);
  localparam logic [IDX_W-1:0] RST_TAIL_C  = IDX_W'(FREE_AT_RST);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             bnk_q, bnk_d;
  logic             deq_fire;
  logic             enq_accept;
  logic             bank_mismatch;

  // A full bank still accepts an enqueue when the head leaves in the same cycle.
  always_comb begin
    deq_fire      = (count_q != '0) & deq_ready;
    enq_accept    = enq_valid & ((count_q < DEPTH_C) | deq_fire);
    bank_mismatch = enq_valid & (enq_PR_tag[BNK_W-1:0] != BANK_BITS);

    head_d  = head_q + IDX_W'(deq_fire);
    tail_d  = tail_q + IDX_W'(enq_accept);
    count_d = count_q;
    unique case ({enq_accept, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (enq_valid & ~enq_accept);
    unf_d = unf_q | (deq_ready & (count_q == '0));
    bnk_d = bnk_q | bank_mismatch;
  end

  // Slots past the initially free PRs reset to zero; they are never read before being written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < FREE_AT_RST) ? IDX_W'(i + AR_PER_BANK) : '0;
      end
    end else if (enq_accept) begin
      mem_q[tail_q] <= enq_PR_tag[TAG_W-1:BNK_W];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= RST_TAIL_C;
      count_q <= RST_CNT_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      bnk_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      bnk_q   <= bnk_d;
    end
  end

  assign deq_valid     = (count_q != '0);
  assign deq_PR_tag    = {mem_q[head_q], BANK_BITS};
  assign count         = count_q;
  assign low_flag      = (count_q < LOW_C);
  assign high_flag     = (count_q > HIGH_C);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign bank_err      = bnk_q;

endmodule

// File: tb/tb_free_list_bank.sv
// Directed self-checking bench for free_list_bank with BANK_ID=2, backed by a
// small FIFO reference queue plus hand-computed constants at key points.
`timescale 1ns/1ps
module tb_free_list_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enq_valid;
  logic [6:0] enq_PR_tag;
  logic       deq_valid;
  logic [6:0] deq_PR_tag;
  logic       deq_ready;
  logic [5:0] count;
  logic       low_flag, high_flag;
  logic       overflow_err, underflow_err, bank_err;

  free_list_bank #(
    .PR_COUNT(128),
    .BANK_COUNT(4),
    .BANK_ID(2),
    .AR_COUNT(32),
    .LOWER_THRESHOLD(8),
    .UPPER_THRESHOLD(24)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .enq_valid(enq_valid),
    .enq_PR_tag(enq_PR_tag),
    .deq_valid(deq_valid),
    .deq_PR_tag(deq_PR_tag),
    .deq_ready(deq_ready),
    .count(count),
    .low_flag(low_flag),
    .high_flag(high_flag),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err),
    .bank_err(bank_err)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int q[$];
  bit ovf_m, unf_m, bnk_m;

  function automatic int tag_of(input int idx);
    return idx * 4 + 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 8; i < 32; i++) q.push_back(i);
    ovf_m = 1'b0;
    unf_m = 1'b0;
    bnk_m = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(deq_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".tag"}, 32'(deq_PR_tag), 32'(tag_of(q[0])));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".low"}, 32'(low_flag), 32'(q.size() < 8));
    chk({tag, ".high"}, 32'(high_flag), 32'(q.size() > 24));
    chk({tag, ".ovf"}, 32'(overflow_err), 32'(ovf_m));
    chk({tag, ".unf"}, 32'(underflow_err), 32'(unf_m));
    chk({tag, ".bnk"}, 32'(bank_err), 32'(bnk_m));
  endtask

  // Drive one clock cycle of stimulus, advance the reference queue, check after the edge.
  task automatic cycle(input string tag, input bit ev, input int etag, input bit dr);
    bit fire, acc;
    enq_valid  = ev;
    enq_PR_tag = 7'(etag);
    deq_ready  = dr;
    fire = dr && (q.size() != 0);
    acc  = ev && ((q.size() < 32) || fire);
    if (dr && !fire) unf_m = 1'b1;
    if (ev && !acc) ovf_m = 1'b1;
    if (ev && (etag[1:0] != 2'd2)) bnk_m = 1'b1;
    if (fire) void'(q.pop_front());
    if (acc) q.push_back(etag >> 2);
    @(posedge CLK);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check_state(tag);
  endtask

  initial begin
    RST        = 1'b1;
    enq_valid  = 1'b0;
    enq_PR_tag = '0;
    deq_ready  = 1'b0;
    model_reset();

    #3;
    chk("rst.valid", 32'(deq_valid), 32'd1);
    chk("rst.tag", 32'(deq_PR_tag), 32'd34);
    chk("rst.count", 32'(count), 32'd24);
    chk("rst.low", 32'(low_flag), 32'd0);
    chk("rst.high", 32'(high_flag), 32'd0);
    chk("rst.errs", 32'({overflow_err, underflow_err, bank_err}), 32'd0);
    #4 RST = 1'b0;

    // Drain the 24 reset entries: tags 34, 38, ..., 126.
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("drain.tag%0d", i), 32'(deq_PR_tag), 32'(34 + 4 * i));
      cycle("drain", 1'b0, 0, 1'b1);
      if (i == 15) chk("drain.low_at8", 32'(low_flag), 32'd0);
      if (i == 16) chk("drain.low_at7", 32'(low_flag), 32'd1);
    end
    chk("drain.empty_valid", 32'(deq_valid), 32'd0);
    chk("drain.empty_count", 32'(count), 32'd0);

    cycle("underflow", 1'b0, 0, 1'b1);
    chk("underflow.err", 32'(underflow_err), 32'd1);
    chk("underflow.count", 32'(count), 32'd0);

    // Empty + enq: no bypass, visible one cycle later.
    #1;
    enq_valid  = 1'b1;
    enq_PR_tag = 7'd66;
    #1;
    chk("empty_enq.same_cycle_valid", 32'(deq_valid), 32'd0);
    cycle("empty_enq", 1'b1, 66, 1'b0);
    chk("empty_enq.valid", 32'(deq_valid), 32'd1);
    chk("empty_enq.tag", 32'(deq_PR_tag), 32'd66);
    chk("empty_enq.count", 32'(count), 32'd1);
    cycle("empty_enq_pop", 1'b0, 0, 1'b1);

    // Wrong bank bits: flagged, but the upper bits are still stored.
    cycle("bank", 1'b1, 65, 1'b0);
    chk("bank.err", 32'(bank_err), 32'd1);
    chk("bank.tag", 32'(deq_PR_tag), 32'd66);
    cycle("bank_pop", 1'b0, 0, 1'b1);

    // Steady-state enq+deq across the pointer wrap with three entries in flight.
    for (int i = 1; i <= 3; i++) cycle("wrap_pre", 1'b1, tag_of(i), 1'b0);
    for (int i = 0; i < 40; i++) cycle("wrap", 1'b1, tag_of((7 * i + 3) % 32), 1'b1);
    chk("wrap.count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, 0, 1'b1);

    // Build up count=13 with head at slot 11, then reset asynchronously mid-cycle.
    for (int i = 0; i < 19; i++) cycle("build", 1'b1, tag_of((5 * i + 1) % 32), 1'b0);
    for (int i = 0; i < 6; i++) cycle("build_pop", 1'b0, 0, 1'b1);
    chk("build.count", 32'(count), 32'd13);
    #2 RST = 1'b1;
    model_reset();
    #1;
    check_state("arst");
    chk("arst.count", 32'(count), 32'd24);
    chk("arst.tag", 32'(deq_PR_tag), 32'd34);
    chk("arst.errs", 32'({overflow_err, underflow_err, bank_err}), 32'd0);
    #1 RST = 1'b0;

    // Fill to 32, drop a 33rd enq, then enq+deq while full.
    for (int i = 0; i < 8; i++) begin
      cycle("fill", 1'b1, tag_of(i), 1'b0);
      if (i == 0) chk("fill.high_at25", 32'(high_flag), 32'd1);
    end
    chk("fill.count", 32'(count), 32'd32);
    cycle("overflow", 1'b1, tag_of(20), 1'b0);
    chk("overflow.err", 32'(overflow_err), 32'd1);
    chk("overflow.count", 32'(count), 32'd32);
    cycle("full_both", 1'b1, tag_of(9), 1'b1);
    chk("full_both.count", 32'(count), 32'd32);
    chk("full_both.tag", 32'(deq_PR_tag), 32'd38);
    for (int i = 0; i < 32; i++) cycle("full_drain", 1'b0, 0, 1'b1);
    chk("full_drain.count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/free_list_bank.md
Name: free_list_bank

Overview:
- One bank of the physical-register free list, sitting between commit/restore and rename.
- Commit enqueues freed PRs and rename dequeues PRs to allocate; this block is the allocation (read) end.
- Circular FIFO of bank-local PR indices, with occupancy count and threshold flags that feed the rename bank-steering logic.
- FREE_LIST_BANK_COUNT instances are built, one per PRF bank.

Parameters:
- PR_COUNT, 128: total physical registers.
- BANK_COUNT, 4: number of banks; PR bank = PR_tag[log2(BANK_COUNT)-1:0].
- BANK_ID, 0: this bank's index, 0..BANK_COUNT-1.
- AR_COUNT, 32: architectural registers, identity-mapped at reset to PR 0..AR_COUNT-1.
- LOWER_THRESHOLD, 8: count below this asserts low_flag.
- UPPER_THRESHOLD, 24: count above this asserts high_flag.
- Derived, not overridable:
  - DEPTH = PR_COUNT/BANK_COUNT (32).
  - IDX_W = log2(DEPTH) (5).
  - TAG_W = log2(PR_COUNT) (7).

Ports:
- CLK, input, 1: clock.
- RST, input, 1: reset, asynchronous, active-high.
- enq_valid, input, 1: freed PR presented.
- enq_PR_tag, input, TAG_W: freed PR. Low log2(BANK_COUNT) bits must equal BANK_ID.
- deq_valid, output, 1: a free PR is available.
- deq_PR_tag, output, TAG_W: PR at head = {head_idx, BANK_ID}.
- deq_ready, input, 1: rename consumes the head this cycle.
- count, output, IDX_W+1: current occupancy, 0..DEPTH.
- low_flag, output, 1: count < LOWER_THRESHOLD.
- high_flag, output, 1: count > UPPER_THRESHOLD.
- overflow_err, output, 1: sticky; set when an enq is dropped.
- underflow_err, output, 1: sticky; set when deq_ready is asserted with deq_valid low.
- bank_err, output, 1: sticky; set when an enq has bank bits != BANK_ID.

Behaviour:
- Storage: DEPTH x IDX_W array of bank-local indices; head and tail pointers IDX_W wide, wrapping naturally mod DEPTH; separate count register IDX_W+1 wide.
- Reset values (async on RST high):
  - array[i] = i + AR_COUNT/BANK_COUNT for i in 0..DEPTH-AR_COUNT/BANK_COUNT-1 (defaults: entries 8..31 in slots 0..23); remaining slots 0.
  - head = 0; tail = DEPTH - AR_COUNT/BANK_COUNT (24); count = 24.
  - Sticky error flags = 0.
  - Outputs after reset (defaults): deq_valid=1; deq_PR_tag = 8*BANK_COUNT+BANK_ID; low_flag=0; high_flag=0.
- Combinational outputs from registers:
  - deq_valid = (count != 0).
  - deq_PR_tag = {array[head], BANK_ID[log2(BANK_COUNT)-1:0]}.
  - Flags derived from the registered count.
- Dequeue: deq_fire = deq_valid & deq_ready. On fire, head increments next cycle and the new head is visible next cycle.
- Enqueue:
  - enq_accept = enq_valid & (count < DEPTH | deq_fire).
  - On accept, array[tail] <= enq_PR_tag[TAG_W-1:log2(BANK_COUNT)] and tail increments.
  - Only the upper bits are stored; bank bits are checked but not stored.
- Count update: count <= count + enq_accept - deq_fire.
- Empty + enq: no bypass. deq_valid stays 0 that cycle and rises the next cycle.
- Empty + deq_ready: no state change; underflow_err set.
- Full + enq + deq_fire in the same cycle: both happen; count stays DEPTH.
- Full + enq without deq_fire: enq dropped; overflow_err set; pointers and count unchanged.
- bank_err: sets on an enq_valid whose bank bits mismatch. The entry is still stored using its upper bits.
- Wrap-around: pointers roll 31 -> 0 with no special handling. Ordering is strict FIFO.
- RST mid-operation: all state returns to reset contents immediately, discarding in-flight enq/deq.
- Latency: enq-to-deq visibility is one cycle minimum when the FIFO is empty.

Test Plan:
- Reset, BANK_ID=2, deq_ready held 1 for 24 cycles -> deq_PR_tag sequence 34, 38, ..., 126; count 24 -> 0; deq_valid drops after cycle 24; low_flag rises when count reaches 7.
- From empty, enq_valid with tag 66 (BANK_ID=2) -> deq_valid=0 that cycle; next cycle deq_valid=1, deq_PR_tag=66, count=1.
- Fill to 32 via 8 enqs from reset (high_flag=1 once count=25) -> 33rd enq without deq is dropped: overflow_err=1, count=32. Then simultaneous enq+deq -> count stays 32 and the enqueued tag appears in FIFO order.
- 40 alternating enq/deq cycles across the pointer wrap -> output order matches input order exactly; count constant.
- deq_ready with count=0 -> underflow_err=1, count stays 0. Enq tag 65 into BANK_ID=2 -> bank_err=1.
- RST pulsed asynchronously mid-stream (count=13, head=11) -> count=24, head=0, deq_PR_tag=34, all errors cleared before the next CLK edge.
